// File: rtl/ip_mac_cam_pkg.sv
// Shared widths and types for the IP->MAC resolution CAM.
// Optional feature macro: ARP_AGING_EN (per-entry expiry, see ip_mac_cam).
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef MAC_ADDR_W
`define MAC_ADDR_W 48
`endif

package ip_mac_cam_pkg;

    localparam int IP_ADDR_W   = `IP_ADDR_W;
    localparam int MAC_ADDR_W  = `MAC_ADDR_W;
    localparam int CAM_ENTRIES = 16;
    localparam int IDX_W       = $clog2(CAM_ENTRIES);
    localparam int CNT_W       = IDX_W + 1;

    typedef struct packed {
        logic                  valid;
        logic [IP_ADDR_W-1:0]  ip;
        logic [MAC_ADDR_W-1:0] mac;
    } cam_entry_t;

    typedef struct packed {
        logic                  hit;
        logic [MAC_ADDR_W-1:0] mac;
    } lk_res_t;

endpackage

// File: rtl/ip_mac_cam_if.sv
// Lookup, write and control bundle of the IP->MAC CAM.
// Optional feature macro: ARP_AGING_EN (no effect on this bundle).
interface ip_mac_cam_if
    import ip_mac_cam_pkg::*;
;
    logic [IP_ADDR_W-1:0]  ip_addr;
    logic                  ip_addr_val;
    logic                  ip_addr_rdy;
    logic [MAC_ADDR_W-1:0] mac_addr;
    logic                  mac_addr_hit;
    logic                  mac_addr_val;
    logic                  mac_addr_rdy;
    logic [IP_ADDR_W-1:0]  wr_ip;
    logic [MAC_ADDR_W-1:0] wr_mac;
    logic                  wr_val;
    logic                  wr_rdy;
    logic                  flush;
    logic [CNT_W-1:0]      num_valid;

    modport master (
        output ip_addr, ip_addr_val, mac_addr_rdy,
        output wr_ip, wr_mac, wr_val, flush,
        input  ip_addr_rdy, mac_addr, mac_addr_hit, mac_addr_val,
        input  wr_rdy, num_valid
    );

    modport slave (
        input  ip_addr, ip_addr_val, mac_addr_rdy,
        input  wr_ip, wr_mac, wr_val, flush,
        output ip_addr_rdy, mac_addr, mac_addr_hit, mac_addr_val,
        output wr_rdy, num_valid
    );
endinterface

// File: rtl/ip_mac_cam_alloc.sv
// Write-slot selection: refresh a matching key, else fill the lowest
// free slot, else replace the round-robin victim. Purely combinational.
module ip_mac_cam_alloc #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [N-1:0]  match_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          is_new_o,
    output logic [IW-1:0] ptr_o
);
    logic [IW-1:0] m_idx;
    logic [IW-1:0] f_idx;

    always_comb begin
        m_idx = '0;
        f_idx = '0;
        // keys are unique, so at most one match bit is set
        for (int i = 0; i < N; i++) begin
            if (match_i[i]) m_idx = m_idx | IW'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_i[i]) f_idx = IW'(i);
        end
        idx_o    = ptr_i;
        is_new_o = 1'b0;
        ptr_o    = ptr_i;
        if (|match_i) begin
            idx_o = m_idx;
        end else if (!(&valid_i)) begin
            idx_o    = f_idx;
            is_new_o = 1'b1;
        end else begin
            ptr_o = ptr_i + IW'(1);
        end
    end
endmodule

// File: rtl/ip_mac_cam.sv
// Fully associative IP->MAC CAM with a registered lookup result.
// Optional feature macro: ARP_AGING_EN enables per-entry expiry after AGE_CYCLES.
module ip_mac_cam
    import ip_mac_cam_pkg::*;
#(
    parameter int NUM_ENTRIES = CAM_ENTRIES
`ifdef ARP_AGING_EN
   ,parameter int AGE_CYCLES  = 2**24
`endif
) (
    input logic         clk,
    input logic         rst,
    ip_mac_cam_if.slave bus
);
    localparam int IW = $clog2(NUM_ENTRIES);

    cam_entry_t [NUM_ENTRIES-1:0] ent_q, ent_d;
    lk_res_t                      res_q, res_d, lk;
    logic                         val_q, val_d;
    logic [IW-1:0]                ptr_q, ptr_d, wr_idx, ptr_nxt;
    logic [CNT_W-1:0]             nv_q, nv_d;
    logic [NUM_ENTRIES-1:0]       vld, lk_match, wr_match, expire;
    logic                         is_new, lk_acc, wr_acc;

    assign bus.ip_addr_rdy  = ~val_q | bus.mac_addr_rdy;
    assign bus.wr_rdy       = ~bus.flush;
    assign bus.mac_addr     = res_q.mac;
    assign bus.mac_addr_hit = res_q.hit;
    assign bus.mac_addr_val = val_q;
    assign bus.num_valid    = nv_q;

    assign lk_acc = bus.ip_addr_val & bus.ip_addr_rdy;
    assign wr_acc = bus.wr_val & ~bus.flush;

    always_comb begin
        lk       = '0;
        vld      = '0;
        lk_match = '0;
        wr_match = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            vld[i]      = ent_q[i].valid;
            lk_match[i] = vld[i] && (ent_q[i].ip == bus.ip_addr);
            wr_match[i] = vld[i] && (ent_q[i].ip == bus.wr_ip);
            if (lk_match[i]) begin
                lk.hit = 1'b1;
                lk.mac = lk.mac | ent_q[i].mac;
            end
        end
    end

    ip_mac_cam_alloc #(.N(NUM_ENTRIES), .IW(IW)) u_alloc (
        .valid_i  (vld),
        .match_i  (wr_match),
        .ptr_i    (ptr_q),
        .idx_o    (wr_idx),
        .is_new_o (is_new),
        .ptr_o    (ptr_nxt)
    );

`ifdef ARP_AGING_EN
    localparam int AW = $clog2(AGE_CYCLES) + 1;

    logic [NUM_ENTRIES-1:0][AW-1:0] age_q, age_d;

    always_comb begin
        age_d  = age_q;
        expire = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (vld[i]) begin
                if (age_q[i] == AW'(AGE_CYCLES - 1))
                    expire[i] = ~(wr_acc && (wr_idx == IW'(i)));
                else
                    age_d[i] = age_q[i] + AW'(1);
            end
        end
        if (wr_acc) age_d[wr_idx] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) age_q <= '0;
        else      age_q <= age_d;
    end
`else
    assign expire = '0;
`endif

    always_comb begin
        val_d = val_q;
        res_d = res_q;
        if (lk_acc) begin
            val_d = 1'b1;
            res_d = lk;
        end else if (bus.mac_addr_rdy) begin
            val_d = 1'b0;
        end
    end

    always_comb begin
        ent_d = ent_q;
        ptr_d = ptr_q;
        nv_d  = nv_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (expire[i]) begin
                ent_d[i].valid = 1'b0;
                nv_d           = nv_d - CNT_W'(1);
            end
        end
        if (bus.flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_d[i].valid = 1'b0;
            ptr_d = '0;
            nv_d  = '0;
        end else if (wr_acc) begin
            ent_d[wr_idx].valid = 1'b1;
            ent_d[wr_idx].ip    = bus.wr_ip;
            ent_d[wr_idx].mac   = bus.wr_mac;
            ptr_d               = ptr_nxt;
            if (is_new) nv_d = nv_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q <= '0;
            ptr_q <= '0;
            nv_q  <= '0;
            val_q <= 1'b0;
            res_q <= '0;
        end else begin
            ent_q <= ent_d;
            ptr_q <= ptr_d;
            nv_q  <= nv_d;
            val_q <= val_d;
            res_q <= res_d;
        end
    end
endmodule
